// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: MIR field positions,
// branch condition codes and FSM state encodings.
package micro_sequencer_pkg;

  localparam int MIR_RD_BIT  = 19;
  localparam int MIR_WR_BIT  = 18;
  localparam int MIR_COND_HI = 13;
  localparam int MIR_COND_LO = 11;
  localparam int MIR_JUMP_HI = 10;
  localparam int MIR_JUMP_LO = 0;
  localparam int JUMP_W      = MIR_JUMP_HI - MIR_JUMP_LO + 1;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    COND_NEXT     = 3'b000,
    COND_N        = 3'b001,
    COND_Z        = 3'b010,
    COND_V        = 3'b011,
    COND_C        = 3'b100,
    COND_IR13     = 3'b101,
    COND_JUMP     = 3'b110,
    COND_DISPATCH = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10,
    ST_FAULT    = 2'b11
  } state_e;

endpackage

// File: rtl/micro_sequencer_next_addr.sv
// Combinational next-microaddress selection: sequential, flag/IR-conditional
// branches, unconditional jump and opcode dispatch.
module microseq_next_addr
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic [ADDR_W-1:0] i_mpc,
  input  logic [2:0]        i_cond,
  input  logic [JUMP_W-1:0] i_jump,
  input  logic [31:0]       i_ir,
  input  logic [3:0]        i_flags,
  output logic [ADDR_W-1:0] o_nextAddr
);

  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_jump;
  logic [10:0]       w_dispatch;
  logic              w_unusedIr;

  // The increment wraps naturally at the top of the control store.
  assign w_inc      = i_mpc + ADDR_W'(1);
  assign w_jump     = ADDR_W'(i_jump);
  assign w_dispatch = {1'b1, i_ir[31:30], i_ir[24:19], 2'b00};
  assign w_unusedIr = ^{i_ir[29:25], i_ir[18:14], i_ir[12:0]};

  always_comb begin
    o_nextAddr = w_inc;
    case (i_cond)
      COND_NEXT:     o_nextAddr = w_inc;
      COND_N:        o_nextAddr = i_flags[FLAG_N] ? w_jump : w_inc;
      COND_Z:        o_nextAddr = i_flags[FLAG_Z] ? w_jump : w_inc;
      COND_V:        o_nextAddr = i_flags[FLAG_V] ? w_jump : w_inc;
      COND_C:        o_nextAddr = i_flags[FLAG_C] ? w_jump : w_inc;
      COND_IR13:     o_nextAddr = i_ir[13] ? w_jump : w_inc;
      COND_JUMP:     o_nextAddr = w_jump;
      COND_DISPATCH: o_nextAddr = ADDR_W'(w_dispatch);
      default:       o_nextAddr = w_inc;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the MPC, stalls on memory handshakes,
// supports halt requests and traps into a terminal fault on memory timeout.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int MIR_BUS_WIDTH       = 41,
  parameter int Direction_BUS_WIDTH = 11,
  parameter int MEM_TIMEOUT         = 255
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET_InHigh,
  input  logic [MIR_BUS_WIDTH-1:0]       MICROSEQ_MIR_IN,
  input  logic [31:0]                    MICROSEQ_IR_IN,
  input  logic [3:0]                     MICROSEQ_Flags_IN,
  input  logic                           MICROSEQ_MemAck_IN,
  input  logic                           MICROSEQ_Halt_IN,
  output logic [Direction_BUS_WIDTH-1:0] MICROSEQ_Direccion_OUT,
  output logic                           MICROSEQ_MirValid_OUT,
  output logic                           MICROSEQ_MemReq_OUT,
  output logic [1:0]                     MICROSEQ_State_OUT
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e                         r_state;
  state_e                         w_nextState;
  logic [Direction_BUS_WIDTH-1:0] r_mpc;
  logic [Direction_BUS_WIDTH-1:0] w_nextAddr;
  logic [CNT_W-1:0]               r_waitCnt;
  logic [CNT_W-1:0]               w_nextWaitCnt;
  logic                           w_memOp;
  logic                           w_active;
  logic                           w_memReq;
  logic                           w_commit;
  logic                           w_timeout;
  logic                           w_unusedMir;

  assign w_memOp     = MICROSEQ_MIR_IN[MIR_RD_BIT] | MICROSEQ_MIR_IN[MIR_WR_BIT];
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
  assign w_memReq    = w_memOp && w_active;
  assign w_commit    = ((r_state == ST_RUN) && !w_memOp) ||
                       (w_memReq && MICROSEQ_MemAck_IN);
  assign w_timeout   = (int'(r_waitCnt) + 1) >= MEM_TIMEOUT;
  assign w_unusedMir = ^{MICROSEQ_MIR_IN[MIR_BUS_WIDTH-1:MIR_RD_BIT+1],
                         MICROSEQ_MIR_IN[MIR_WR_BIT-1:MIR_COND_HI+1]};

  microseq_next_addr #(
    .ADDR_W(Direction_BUS_WIDTH)
  ) u_nextAddr (
    .i_mpc      (r_mpc),
    .i_cond     (MICROSEQ_MIR_IN[MIR_COND_HI:MIR_COND_LO]),
    .i_jump     (MICROSEQ_MIR_IN[MIR_JUMP_HI:MIR_JUMP_LO]),
    .i_ir       (MICROSEQ_IR_IN),
    .i_flags    (MICROSEQ_Flags_IN),
    .o_nextAddr (w_nextAddr)
  );

  // A halt request raised while waiting on memory takes effect on the completing cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    case (r_state)
      ST_RUN: begin
        if (w_commit) begin
          if (MICROSEQ_Halt_IN) w_nextState = ST_HALT;
        end else begin
          w_nextState   = ST_MEM_WAIT;
          w_nextWaitCnt = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (w_commit) begin
          w_nextState = MICROSEQ_Halt_IN ? ST_HALT : ST_RUN;
        end else begin
          w_nextWaitCnt = r_waitCnt + CNT_W'(1);
          if (w_timeout) w_nextState = ST_FAULT;
        end
      end
      ST_HALT: begin
        if (!MICROSEQ_Halt_IN) w_nextState = ST_RUN;
      end
      ST_FAULT: w_nextState = ST_FAULT;
      default:  w_nextState = ST_RUN;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      r_state   <= ST_RUN;
      r_mpc     <= '0;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_commit) r_mpc <= w_nextAddr;
    end
  end

  assign MICROSEQ_Direccion_OUT = r_mpc;
  assign MICROSEQ_MirValid_OUT  = w_commit;
  assign MICROSEQ_MemReq_OUT    = w_memReq;
  assign MICROSEQ_State_OUT     = r_state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: table of branch vectors plus
// hand-written memory-wait, timeout, halt and reset sequences.
module tb_micro_sequencer;

  logic        clock;
  logic        reset;
  logic [40:0] mir;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        memAck;
  logic        halt;
  logic [10:0] direccion;
  logic        mirValid;
  logic        memReq;
  logic [1:0]  state;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [10:0] startMpc;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [10:0] expNext;
  } vec_t;

  vec_t vecs[15];

  micro_sequencer #(
    .MIR_BUS_WIDTH       (41),
    .Direction_BUS_WIDTH (11),
    .MEM_TIMEOUT         (4)
  ) dut (
    .CLOCK_50               (clock),
    .RESET_InHigh           (reset),
    .MICROSEQ_MIR_IN        (mir),
    .MICROSEQ_IR_IN         (ir),
    .MICROSEQ_Flags_IN      (flags),
    .MICROSEQ_MemAck_IN     (memAck),
    .MICROSEQ_Halt_IN       (halt),
    .MICROSEQ_Direccion_OUT (direccion),
    .MICROSEQ_MirValid_OUT  (mirValid),
    .MICROSEQ_MemReq_OUT    (memReq),
    .MICROSEQ_State_OUT     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upper MIR bits carry noise that the sequencer must ignore.
  function automatic logic [40:0] mkMir(input logic rd, input logic wr,
                                        input logic [2:0] cond, input logic [10:0] jump);
    logic [40:0] m;
    m        = '0;
    m[40:20] = 21'h1A5A5;
    m[17:14] = 4'hA;
    m[19]    = rd;
    m[18]    = wr;
    m[13:11] = cond;
    m[10:0]  = jump;
    return m;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [40:0] m, input logic [31:0] i,
                               input logic [3:0] f, input logic ack, input logic h);
    mir    = m;
    ir     = i;
    flags  = f;
    memAck = ack;
    halt   = h;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic gotoAddr(input logic [10:0] a);
    applyStimulus(mkMir(1'b0, 1'b0, 3'b110, a), 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{11'd5,    3'b000, 11'h123, 32'h0000_0000, 4'b0000, 11'd6};
    vecs[1]  = '{11'd2047, 3'b000, 11'h123, 32'h0000_0000, 4'b0000, 11'd0};
    vecs[2]  = '{11'h010,  3'b010, 11'h123, 32'h0000_0000, 4'b0100, 11'h123};
    vecs[3]  = '{11'h010,  3'b010, 11'h123, 32'h0000_0000, 4'b1011, 11'h011};
    vecs[4]  = '{11'h020,  3'b001, 11'h045, 32'h0000_0000, 4'b1000, 11'h045};
    vecs[5]  = '{11'h020,  3'b001, 11'h045, 32'h0000_0000, 4'b0111, 11'h021};
    vecs[6]  = '{11'h030,  3'b011, 11'h2AA, 32'h0000_0000, 4'b0010, 11'h2AA};
    vecs[7]  = '{11'h030,  3'b100, 11'h7FF, 32'h0000_0000, 4'b1110, 11'h031};
    vecs[8]  = '{11'h030,  3'b100, 11'h7FF, 32'h0000_0000, 4'b0001, 11'h7FF};
    vecs[9]  = '{11'h040,  3'b101, 11'h100, 32'h0000_2000, 4'b0000, 11'h100};
    vecs[10] = '{11'h040,  3'b101, 11'h100, 32'hFFFF_DFFF, 4'b1111, 11'h041};
    vecs[11] = '{11'h050,  3'b110, 11'h3C3, 32'h0000_0000, 4'b0000, 11'h3C3};
    vecs[12] = '{11'h060,  3'b111, 11'h000, 32'h81C0_0000, 4'b0000, 11'h6E0};
    vecs[13] = '{11'h060,  3'b111, 11'h000, 32'h41C0_0000, 4'b0000, 11'h5E0};
    vecs[14] = '{11'h060,  3'b111, 11'h7FF, 32'h3E3F_FFFF, 4'b0000, 11'h41C};

    reset = 1'b1;
    applyStimulus(mkMir(1'b0, 1'b0, 3'b000, 11'h0), 32'h0, 4'h0, 1'b0, 1'b0);
    #20;
    checkOutput("reset_mpc", 32'(direccion), 32'h0);
    checkOutput("reset_state", 32'(state), 32'h0);
    checkOutput("reset_mirvalid", 32'(mirValid), 32'h1);
    checkOutput("reset_memreq", 32'(memReq), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    checkOutput("first_commit", 32'(direccion), 32'h1);

    for (int k = 0; k < 15; k++) begin
      gotoAddr(vecs[k].startMpc);
      checkOutput($sformatf("vec%0d_start", k), 32'(direccion), 32'(vecs[k].startMpc));
      applyStimulus(mkMir(1'b0, 1'b0, vecs[k].cond, vecs[k].jump), vecs[k].ir,
                    vecs[k].flags, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_valid", k), 32'(mirValid), 32'h1);
      checkOutput($sformatf("vec%0d_memreq", k), 32'(memReq), 32'h0);
      tick();
      checkOutput($sformatf("vec%0d_next", k), 32'(direccion), 32'(vecs[k].expNext));
    end

    // Read acknowledged on the third wait cycle.
    gotoAddr(11'h100);
    applyStimulus(mkMir(1'b1, 1'b0, 3'b000, 11'h0), 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("rd_run_memreq", 32'(memReq), 32'h1);
    checkOutput("rd_run_valid", 32'(mirValid), 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      memAck = (k == 2);
      #1;
      checkOutput($sformatf("rd_wait%0d_state", k), 32'(state), 32'h1);
      checkOutput($sformatf("rd_wait%0d_memreq", k), 32'(memReq), 32'h1);
      checkOutput($sformatf("rd_wait%0d_valid", k), 32'(mirValid), 32'((k == 2) ? 1 : 0));
      checkOutput($sformatf("rd_wait%0d_mpc", k), 32'(direccion), 32'h100);
      tick();
    end
    applyStimulus(mkMir(1'b0, 1'b0, 3'b110, 11'h222), 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("rd_done_state", 32'(state), 32'h0);
    checkOutput("rd_done_mpc", 32'(direccion), 32'h101);

    // Acknowledge arriving on the timeout cycle still commits.
    gotoAddr(11'h200);
    applyStimulus(mkMir(1'b0, 1'b1, 3'b110, 11'h155), 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    memAck = 1'b1;
    #1;
    checkOutput("ackwin_state", 32'(state), 32'h1);
    checkOutput("ackwin_valid", 32'(mirValid), 32'h1);
    tick();
    memAck = 1'b0;
    #1;
    checkOutput("ackwin_after_state", 32'(state), 32'h0);
    checkOutput("ackwin_after_mpc", 32'(direccion), 32'h155);

    // Write never acknowledged: fault after four wait cycles.
    gotoAddr(11'h300);
    applyStimulus(mkMir(1'b0, 1'b1, 3'b110, 11'h0AB), 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("to_wait%0d_state", k), 32'(state), 32'h1);
      tick();
    end
    checkOutput("to_fault_state", 32'(state), 32'h3);
    checkOutput("to_fault_memreq", 32'(memReq), 32'h0);
    checkOutput("to_fault_valid", 32'(mirValid), 32'h0);
    applyStimulus(mkMir(1'b0, 1'b0, 3'b000, 11'h0), 32'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("fault_nop_valid", 32'(mirValid), 32'h0);
    tick();
    tick();
    checkOutput("fault_hold_mpc", 32'(direccion), 32'h300);
    checkOutput("fault_hold_state", 32'(state), 32'h3);
    memAck = 1'b0;
    doReset();
    checkOutput("fault_reset_mpc", 32'(direccion), 32'h0);
    checkOutput("fault_reset_state", 32'(state), 32'h0);

    // Halt sampled on a commit at MPC 7.
    gotoAddr(11'd7);
    applyStimulus(mkMir(1'b0, 1'b0, 3'b000, 11'h0), 32'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("halt_commit_valid", 32'(mirValid), 32'h1);
    tick();
    applyStimulus(mkMir(1'b1, 1'b0, 3'b000, 11'h0), 32'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("halt_mpc", 32'(direccion), 32'd8);
    checkOutput("halt_state", 32'(state), 32'h2);
    checkOutput("halt_memreq", 32'(memReq), 32'h0);
    checkOutput("halt_valid", 32'(mirValid), 32'h0);
    tick();
    applyStimulus(mkMir(1'b0, 1'b0, 3'b000, 11'h0), 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("halt_hold_state", 32'(state), 32'h2);
    checkOutput("halt_hold_mpc", 32'(direccion), 32'd8);
    tick();
    checkOutput("unhalt_state", 32'(state), 32'h0);
    checkOutput("unhalt_mpc", 32'(direccion), 32'd8);
    tick();
    checkOutput("unhalt_step_mpc", 32'(direccion), 32'd9);

    // Reset in the middle of a memory wait aborts it without committing.
    gotoAddr(11'h0AA);
    applyStimulus(mkMir(1'b1, 1'b0, 3'b110, 11'h333), 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    checkOutput("abort_wait_state", 32'(state), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_async_mpc", 32'(direccion), 32'h0);
    checkOutput("abort_async_state", 32'(state), 32'h0);
    memAck = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    memAck = 1'b0;
    #1;
    checkOutput("abort_after_mpc", 32'(direccion), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
